// File: rtl/serial_bit_feeder_if.sv
// ============================================================================
// serial_bit_feeder_if : word handshake in, bit stream out, for serial_bit_feeder
// Revision: 1.0
// ============================================================================
`default_nettype none

interface serial_bit_feeder_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             sdata;
  logic             svalid;
  logic             word_done;
  logic             busy;

  modport master (
    output in_data, in_valid,
    input  in_ready, sdata, svalid, word_done, busy
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, sdata, svalid, word_done, busy
  );
endinterface

`default_nettype wire

// File: rtl/serial_bit_feeder.sv
// ============================================================================
// serial_bit_feeder : MSB-first parallel-to-serial feeder with one-word hold.
// Optional even-parity tail bit when SERIAL_FEEDER_PARITY_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_bit_feeder #(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  serial_bit_feeder_if.slave bus
);

`ifdef SERIAL_FEEDER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int            BCW    = $clog2(FRAME);
  localparam logic [BCW-1:0] c_LAST = BCW'(FRAME - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_sreg, w_sreg_nxt;
  logic [BCW-1:0]   r_bcnt, w_bcnt_nxt;
  logic [WIDTH-1:0] r_hold, w_hold_nxt;
  logic             r_hold_full, w_hold_full_nxt;

  logic w_ready, w_accept, w_last;
  logic w_load_in, w_load_hold, w_hold_we;
  logic w_tail;

  assign w_ready  = !r_hold_full && !reset;
  assign w_accept = bus.in_valid && w_ready;
  assign w_last   = (r_bcnt == c_LAST);

  always_comb begin
    w_state_nxt     = r_state;
    w_sreg_nxt      = r_sreg;
    w_bcnt_nxt      = r_bcnt;
    w_hold_nxt      = r_hold;
    w_hold_full_nxt = r_hold_full;
    w_load_in       = 1'b0;
    w_load_hold     = 1'b0;
    w_hold_we       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_load_in   = 1'b1;
          w_sreg_nxt  = bus.in_data;
          w_bcnt_nxt  = '0;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (!w_last) begin
          w_sreg_nxt = {r_sreg[WIDTH-2:0], w_tail};
          w_bcnt_nxt = r_bcnt + 1'b1;
          if (w_accept) begin
            w_hold_we       = 1'b1;
            w_hold_nxt      = bus.in_data;
            w_hold_full_nxt = 1'b1;
          end
        end else if (r_hold_full) begin
          w_load_hold     = 1'b1;
          w_sreg_nxt      = r_hold;
          w_hold_full_nxt = 1'b0;
          w_bcnt_nxt      = '0;
        end else if (w_accept) begin
          // bypass hold so a word arriving on the last-bit edge streams gaplessly
          w_load_in  = 1'b1;
          w_sreg_nxt = bus.in_data;
          w_bcnt_nxt = '0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_sreg      <= '0;
      r_bcnt      <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sreg      <= w_sreg_nxt;
      r_bcnt      <= w_bcnt_nxt;
      r_hold      <= w_hold_nxt;
      r_hold_full <= w_hold_full_nxt;
    end
  end

`ifdef SERIAL_FEEDER_PARITY_EN
  // parity rides behind the data and is shifted into the MSB after WIDTH bits
  logic r_spar, r_hpar;

  assign w_tail = r_spar;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_spar <= 1'b0;
      r_hpar <= 1'b0;
    end else begin
      if (w_load_in)
        r_spar <= ^bus.in_data;
      else if (w_load_hold)
        r_spar <= r_hpar;
      if (w_hold_we)
        r_hpar <= ^bus.in_data;
    end
  end
`else
  assign w_tail = 1'b0;
`endif

  assign bus.in_ready  = w_ready;
  assign bus.svalid    = (r_state == S_SHIFT);
  assign bus.sdata     = (r_state == S_SHIFT) ? r_sreg[WIDTH-1] : IDLE_BIT;
  assign bus.word_done = (r_state == S_SHIFT) && w_last;
  assign bus.busy      = (r_state == S_SHIFT) || r_hold_full;

endmodule

`default_nettype wire

// File: tb/tb_serial_bit_feeder.sv
// ============================================================================
// tb_serial_bit_feeder : vector table, corner sequences and random traffic
// checked against a bit-queue reference model. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_serial_bit_feeder;

  localparam int   WIDTH = 8;
  localparam logic IDLE  = 1'b1;
`ifdef SERIAL_FEEDER_PARITY_EN
  localparam int   FRAME = WIDTH + 1;
  localparam bit   PAR   = 1'b1;
`else
  localparam int   FRAME = WIDTH;
  localparam bit   PAR   = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  serial_bit_feeder_if #(.WIDTH(WIDTH)) bus ();

  serial_bit_feeder #(.WIDTH(WIDTH), .IDLE_BIT(IDLE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: queue of frame bits still to appear; front is the bit on sdata now.
  logic mq[$];
  logic mw[$];

  task automatic push_frame(input logic [WIDTH-1:0] d);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      mq.push_back(d[i]);
      mw.push_back((i == 0) && !PAR);
    end
    if (PAR) begin
      mq.push_back(^d);
      mw.push_back(1'b1);
    end
  endtask

  task automatic compare_all(input logic r);
    logic sv;
    sv = (mq.size() > 0);
    chk("svalid",    bus.svalid,    sv);
    chk("sdata",     bus.sdata,     sv ? mq[0] : IDLE);
    chk("word_done", bus.word_done, sv ? mw[0] : 1'b0);
    chk("busy",      bus.busy,      sv);
    chk("in_ready",  bus.in_ready,  !r && (mq.size() <= FRAME));
  endtask

  task automatic step(input logic r, input logic v, input logic [WIDTH-1:0] d);
    logic acc;
    reset        = r;
    bus.in_valid = v;
    bus.in_data  = d;
    acc = v && !r && (mq.size() <= FRAME);
    @(posedge clk);
    if (r) begin
      mq.delete();
      mw.delete();
    end else begin
      if (mq.size() > 0) begin
        void'(mq.pop_front());
        void'(mw.pop_front());
      end
      if (acc) push_frame(d);
    end
    #1;
    compare_all(r);
  endtask

  typedef struct {
    logic             rst;
    logic             vld;
    logic [WIDTH-1:0] dat;
    logic             e_sv;
    logic             e_sd;
    logic             e_wd;
    logic             e_rdy;
    logic             e_busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic v, logic [WIDTH-1:0] d,
                              logic sv, logic sd, logic wd, logic rdy, logic bz);
    vec_t t;
    t.rst = r; t.vld = v; t.dat = d;
    t.e_sv = sv; t.e_sd = sd; t.e_wd = wd; t.e_rdy = rdy; t.e_busy = bz;
    return t;
  endfunction

  initial begin
    int  lowcnt;
    bit  accepted;
    logic r;
    logic v;

    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // single word 8'hD8: bits 1,1,0,1,1,0,0,0 (+ parity 0)
    tbl.push_back(mk(1, 0, 8'h00, 0, IDLE, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, IDLE, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8'hD8, 1, 1, 0, 1, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 1, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 1, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 1, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, !PAR, 1, 1));
    if (PAR) tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, IDLE, 0, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, IDLE, 0, 1, 0));

    foreach (tbl[i]) begin
      reset        = tbl[i].rst;
      bus.in_valid = tbl[i].vld;
      bus.in_data  = tbl[i].dat;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_svalid", i),    bus.svalid,    tbl[i].e_sv);
      chk($sformatf("tbl%0d_sdata", i),     bus.sdata,     tbl[i].e_sd);
      chk($sformatf("tbl%0d_word_done", i), bus.word_done, tbl[i].e_wd);
      chk($sformatf("tbl%0d_in_ready", i),  bus.in_ready,  tbl[i].e_rdy);
      chk($sformatf("tbl%0d_busy", i),      bus.busy,      tbl[i].e_busy);
    end

    // back-to-back D8, 1B, then a third word held off while hold is full
    step(1, 0, '0);
    step(0, 0, '0);
    step(0, 1, 8'hD8);
    step(0, 1, 8'h1B);
    lowcnt   = 0;
    accepted = 1'b0;
    for (int i = 0; i < 3 * FRAME && !accepted; i++) begin
      if (bus.in_ready === 1'b1) accepted = 1'b1;
      else lowcnt++;
      step(0, 1, 8'hA5);
    end
    chk("third_word_accepted", accepted, 1'b1);
    chk("ready_low_cycles", lowcnt, FRAME - 1);
    repeat (3 * FRAME + 2) step(0, 0, '0);

    // bypass: next word accepted exactly on the last-bit edge
    step(0, 1, 8'h3C);
    repeat (FRAME - 1) step(0, 0, '0);
    chk("bypass_last_bit", bus.word_done, 1'b1);
    step(0, 1, 8'hC3);
    chk("bypass_no_gap", bus.svalid, 1'b1);
    repeat (FRAME + 2) step(0, 0, '0);

    // reset at bit 3 with hold full: both words discarded
    step(0, 1, 8'hF0);
    step(0, 1, 8'h0F);
    step(0, 0, '0);
    step(0, 0, '0);
    chk("pre_reset_busy", bus.busy, 1'b1);
    step(1, 0, '0);
    chk("rst_svalid", bus.svalid, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    repeat (FRAME + 2) step(0, 0, '0);

    // parity-sensitive words
    step(0, 1, 8'hD8);
    repeat (FRAME + 1) step(0, 0, '0);
    step(0, 1, 8'hD9);
    repeat (FRAME + 1) step(0, 0, '0);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      r = ($urandom_range(0, 59) == 0);
      v = ($urandom_range(0, 9) < 7);
      step(r, v, WIDTH'($urandom));
    end
    repeat (2 * FRAME + 2) step(0, 0, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_bit_feeder.md
# serial_bit_feeder

Parallel-to-serial front end for the bit-serial pattern detectors. It accepts WIDTH-bit words over a valid/ready handshake and emits them MSB-first, one bit per clk, on a single-bit stream. That stream drives the detector's `x` input directly. A one-word holding register lets back-to-back words stream with no idle gap between them.

## Interface
Parameters:
- WIDTH, 8, data bits per word; legal range 2..32.
- IDLE_BIT, 1'b0, level driven on `sdata` when no bit is valid.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- in_data  in  WIDTH  word to serialize.
- in_valid  in  1  `in_data` is valid.
- in_ready  out  1  feeder can take a word; computed as `!hold_full && !reset`.
- sdata  out  1  serial bit; equals `sreg[WIDTH-1]` while `svalid` is high, otherwise IDLE_BIT.
- svalid  out  1  `sdata` carries a real bit this cycle.
- word_done  out  1  high during the last bit cycle of each frame.
- busy  out  1  equals `svalid | hold_full`.

## Operation
- Internal state:
  - `state` ∈ {IDLE, SHIFT}
  - `sreg` (WIDTH bits)
  - `bcnt` (bit index, wide enough for FRAME-1)
  - `hold` (WIDTH bits) and `hold_full`
- FRAME = WIDTH, or WIDTH+1 when parity is enabled (see Configuration).
- A word is accepted on any rising edge where `in_valid && in_ready` are both high. The source must hold `in_data` stable until that edge.
- IDLE:
  - On accept: `sreg <= in_data`, `bcnt <= 0`, go to SHIFT.
  - `hold_full` is always 0 in IDLE.
- SHIFT, on every edge:
  - If `bcnt != FRAME-1`: shift `sreg` left by one and increment `bcnt`. An accept on this edge loads `hold` and sets `hold_full`.
  - If `bcnt == FRAME-1` (last bit):
    - If `hold_full`: `sreg <= hold`, clear `hold_full`, `bcnt <= 0`, stay in SHIFT. The next bit is the new word's MSB.
    - Else, if an accept occurs on this edge: `sreg <= in_data` directly (bypassing `hold`), `bcnt <= 0`, stay in SHIFT.
    - Else: go to IDLE.
- `hold_full` set and a last-bit transfer on the same edge: the transfer consumes `hold`. An accept on that edge is impossible because `in_ready` is 0.
- Bit order is strictly MSB first. Bits are never reordered or dropped once a word is accepted.
- Reset while a frame is in flight aborts it. Both the shifter word and the held word are discarded, and no `word_done` is issued.

## Timing
- Reset values:
  - Registers: `state` = IDLE, `sreg` = 0, `bcnt` = 0, `hold_full` = 0.
  - Outputs during and after reset: `svalid` = 0, `sdata` = IDLE_BIT, `word_done` = 0, `busy` = 0.
  - `in_ready` is 0 while `reset` is high and 1 in the first cycle after reset is released.
- Latency: for a word accepted at edge N from IDLE, bit k of the frame (MSB is k=0) is on `sdata` in the cycle after edge N+k.
- Throughput is one bit per clk. Continuous streaming needs each new word accepted no later than the last-bit edge of the current frame.
- Up to two words are in flight: one in the shifter, one in `hold`. `in_ready` drops in the cycle after `hold` is filled and rises in the cycle after the last-bit transfer empties it.
- `word_done` is combinational from `state` and `bcnt` and is high for exactly one cycle per frame.
- The output stream is glitch-level only. Downstream logic samples `sdata` on the same clk edge.

## Configuration
- Macro: `SERIAL_FEEDER_PARITY_EN`.
- Defined: each frame carries one extra bit after the WIDTH data bits, equal to the XOR of the word (even parity). FRAME = WIDTH+1. The parity bit is computed at load time and stored alongside `sreg`, and `word_done` coincides with the parity bit.
- Undefined: FRAME = WIDTH, no parity logic is built, and `word_done` coincides with the LSB.

## Test plan
- Reset release, then a single word 8'hD8 with parity off → `sdata` is 1,1,0,1,1,0,0,0 in cycles 1–8 after the accept. `word_done` is high in cycle 8. The attached detector outputs 1 after the fifth bit. Afterwards `svalid` = 0 and `sdata` = IDLE_BIT.
- Two accepts, 8'hD8 then 8'h1B, on consecutive edges → 16 contiguous `svalid` cycles carrying bits 11011000 00011011. `in_ready` is 0 from the cycle after the second accept until the cycle after the first frame's last bit.
- Third word offered while `hold_full` is set → not accepted. `in_ready` stays 0 for 7 cycles, then the word is accepted and streamed gaplessly after the second frame.
- Word accepted exactly on the last-bit edge with `hold` empty (bypass path) → no idle cycle between frames, and `bcnt` restarts at 0.
- Reset asserted at bit 3 of a frame while `hold_full` = 1 → on the next edge `svalid` = 0, `busy` = 0, `in_ready` = 0. No `word_done` is issued. Neither word reappears after reset is released.
- With `SERIAL_FEEDER_PARITY_EN` defined: word 8'hD8 gives 9 bits ending in 0, and word 8'hD9 gives 9 bits ending in 1. `word_done` is high on bit 9 in both cases.
